game_flow_ctrl: RTL and testbench

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_game_flow_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl
// Top-level game sequencer: requests a random hole layout, runs the ball
// through PLAYING, shows FAIL/WIN for RESULT_HOLD cycles, and tracks
// level / lives / score until GAMEOVER or DONE.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_restart                 restart the game from level 0
//   i_rand_ready, i_rand_list random layout handshake and payload
//                             (x fields in low half, y fields in high half;
//                             each half = fail holes, win hole, ball init)
//   i_fail, i_win             ball entered a fail / win hole
//   i_roll_x/y, i_fix_x/y     rolling ball position, rest position in hole
//   o_rand_req, o_ball_rst    one-cycle request / ball-mover restart pulses
//   o_playing, o_state        state flags
//   o_level, o_lives, o_score game progress
//   o_fh_*, o_wh_*, o_bl_init_*  latched layout and fail-hole enable mask
//   o_bl_x/y                  ball position to draw
module game_flow_ctrl #(
    parameter int MAX_FAILHOLE_NUM = 7,
    parameter int COORD_W          = 10,
    parameter int NUM_LEVELS       = 4,
    parameter int LIVES            = 3,
    parameter int FH_BASE          = 3,
    parameter int RESULT_HOLD      = 50000000,
    parameter int SCORE_W          = 8,
    parameter int SPRITE_BL_X      = 144,
    parameter int SPRITE_BL_Y      = 74,
    localparam int N      = MAX_FAILHOLE_NUM,
    localparam int LVL_W  = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
    localparam int LIV_W  = $clog2(LIVES + 1),
    localparam int LIST_W = 2 * COORD_W * (N + 2)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_restart,
    input  logic                   i_rand_ready,
    input  logic [LIST_W-1:0]      i_rand_list,
    input  logic                   i_fail,
    input  logic                   i_win,
    input  logic [COORD_W-1:0]     i_roll_x,
    input  logic [COORD_W-1:0]     i_roll_y,
    input  logic [COORD_W-1:0]     i_fix_x,
    input  logic [COORD_W-1:0]     i_fix_y,
    output logic                   o_rand_req,
    output logic                   o_ball_rst,
    output logic                   o_playing,
    output logic [2:0]             o_state,
    output logic [LVL_W-1:0]       o_level,
    output logic [LIV_W-1:0]       o_lives,
    output logic [SCORE_W-1:0]     o_score,
    output logic [COORD_W*N-1:0]   o_fh_pos_x,
    output logic [COORD_W*N-1:0]   o_fh_pos_y,
    output logic [N-1:0]           o_fh_active,
    output logic [COORD_W-1:0]     o_wh_pos_x,
    output logic [COORD_W-1:0]     o_wh_pos_y,
    output logic [COORD_W-1:0]     o_bl_init_x,
    output logic [COORD_W-1:0]     o_bl_init_y,
    output logic [COORD_W-1:0]     o_bl_x,
    output logic [COORD_W-1:0]     o_bl_y
);

    localparam int HALF   = COORD_W * (N + 2);
    localparam int HOLD_W = (RESULT_HOLD > 1) ? $clog2(RESULT_HOLD) : 1;

    typedef enum logic [2:0] {
        S_LOAD     = 3'd0,
        S_PLAYING  = 3'd1,
        S_FAIL     = 3'd2,
        S_WIN      = 3'd3,
        S_GAMEOVER = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [COORD_W-1:0]  fix_x;
    logic [COORD_W-1:0]  fix_y;
    logic [N-1:0]        fh_mask;
    logic                hold_done;

    // Enable mask for the current level: bit k set iff k < FH_BASE + level
    // (the loop bound caps it at N).
    always_comb begin
        fh_mask = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k < (FH_BASE + int'(o_level)))
                fh_mask[k] = 1'b1;
        end
    end

    assign hold_done = (hold_cnt == HOLD_W'(RESULT_HOLD - 1));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_LOAD;
            o_rand_req  <= 1'b1;
            o_ball_rst  <= 1'b0;
            o_level     <= '0;
            o_lives     <= LIV_W'(LIVES);
            o_score     <= '0;
            hold_cnt    <= '0;
            o_fh_pos_x  <= '0;
            o_fh_pos_y  <= '0;
            o_fh_active <= '0;
            o_wh_pos_x  <= '0;
            o_wh_pos_y  <= '0;
            o_bl_init_x <= COORD_W'(SPRITE_BL_X);
            o_bl_init_y <= COORD_W'(SPRITE_BL_Y);
            fix_x       <= '0;
            fix_y       <= '0;
        end else if (i_restart) begin
            state      <= S_LOAD;
            o_rand_req <= 1'b1;
            o_ball_rst <= 1'b0;
            o_level    <= '0;
            o_lives    <= LIV_W'(LIVES);
            o_score    <= '0;
            hold_cnt   <= '0;
        end else begin
            // Pulses default low; state entries below raise them.
            o_rand_req <= 1'b0;
            o_ball_rst <= 1'b0;
            case (state)
                S_LOAD: begin
                    // o_rand_req high marks the first LOAD cycle, where a
                    // stale ready from the previous layout must be ignored.
                    if (!o_rand_req && i_rand_ready) begin
                        o_fh_pos_x  <= i_rand_list[0 +: COORD_W*N];
                        o_wh_pos_x  <= i_rand_list[COORD_W*N +: COORD_W];
                        o_bl_init_x <= i_rand_list[COORD_W*(N+1) +: COORD_W];
                        o_fh_pos_y  <= i_rand_list[HALF +: COORD_W*N];
                        o_wh_pos_y  <= i_rand_list[HALF+COORD_W*N +: COORD_W];
                        o_bl_init_y <= i_rand_list[HALF+COORD_W*(N+1) +: COORD_W];
                        o_fh_active <= fh_mask;
                        o_ball_rst  <= 1'b1;
                        state       <= S_PLAYING;
                    end
                end
                S_PLAYING: begin
                    if (i_fail) begin
                        o_lives  <= o_lives - LIV_W'(1);
                        fix_x    <= i_fix_x;
                        fix_y    <= i_fix_y;
                        hold_cnt <= '0;
                        state    <= S_FAIL;
                    end else if (i_win) begin
                        if (o_score != '1)
                            o_score <= o_score + SCORE_W'(1);
                        fix_x    <= i_fix_x;
                        fix_y    <= i_fix_y;
                        hold_cnt <= '0;
                        state    <= S_WIN;
                    end
                end
                S_FAIL: begin
                    if (hold_done) begin
                        if (o_lives == '0) begin
                            state <= S_GAMEOVER;
                        end else begin
                            o_ball_rst <= 1'b1;
                            state      <= S_PLAYING;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_WIN: begin
                    if (hold_done) begin
                        if (o_level == LVL_W'(NUM_LEVELS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            o_level    <= o_level + LVL_W'(1);
                            o_rand_req <= 1'b1;
                            state      <= S_LOAD;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_GAMEOVER, S_DONE: begin
                    state <= state;
                end
                default: begin
                    o_rand_req <= 1'b1;
                    state      <= S_LOAD;
                end
            endcase
        end
    end

    assign o_state   = state;
    assign o_playing = (state == S_PLAYING);

    always_comb begin
        o_bl_x = fix_x;
        o_bl_y = fix_y;
        case (state)
            S_PLAYING: begin
                o_bl_x = i_roll_x;
                o_bl_y = i_roll_y;
            end
            S_LOAD: begin
                o_bl_x = o_bl_init_x;
                o_bl_y = o_bl_init_y;
            end
            default: begin
                o_bl_x = fix_x;
                o_bl_y = fix_y;
            end
        endcase
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl (RESULT_HOLD=4, other parameters default).
// A game-level model tracks the expected outputs and is compared every
// negative clock edge; directed scenarios add literal expectations.
module tb_game_flow_ctrl;

    localparam int N   = 7;
    localparam int CW  = 10;
    localparam int RH  = 4;
    localparam int LW  = 2 * CW * (N + 2);
    localparam int HALF = CW * (N + 2);

    logic           i_clk = 1'b0;
    logic           i_rst_n, i_restart, i_rand_ready, i_fail, i_win;
    logic [LW-1:0]  i_rand_list;
    logic [CW-1:0]  i_roll_x, i_roll_y, i_fix_x, i_fix_y;
    logic           o_rand_req, o_ball_rst, o_playing;
    logic [2:0]     o_state;
    logic [1:0]     o_level;
    logic [1:0]     o_lives;
    logic [7:0]     o_score;
    logic [CW*N-1:0] o_fh_pos_x, o_fh_pos_y;
    logic [N-1:0]   o_fh_active;
    logic [CW-1:0]  o_wh_pos_x, o_wh_pos_y, o_bl_init_x, o_bl_init_y, o_bl_x, o_bl_y;

    game_flow_ctrl #(.RESULT_HOLD(RH)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_restart(i_restart),
        .i_rand_ready(i_rand_ready), .i_rand_list(i_rand_list),
        .i_fail(i_fail), .i_win(i_win),
        .i_roll_x(i_roll_x), .i_roll_y(i_roll_y),
        .i_fix_x(i_fix_x), .i_fix_y(i_fix_y),
        .o_rand_req(o_rand_req), .o_ball_rst(o_ball_rst), .o_playing(o_playing),
        .o_state(o_state), .o_level(o_level), .o_lives(o_lives), .o_score(o_score),
        .o_fh_pos_x(o_fh_pos_x), .o_fh_pos_y(o_fh_pos_y), .o_fh_active(o_fh_active),
        .o_wh_pos_x(o_wh_pos_x), .o_wh_pos_y(o_wh_pos_y),
        .o_bl_init_x(o_bl_init_x), .o_bl_init_y(o_bl_init_y),
        .o_bl_x(o_bl_x), .o_bl_y(o_bl_y)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- game-level model ----------------
    // States: 0 LOAD, 1 PLAYING, 2 FAIL, 3 WIN, 4 GAMEOVER, 5 DONE
    int m_st, m_lvl, m_lives, m_score, m_left;
    bit m_rr, m_brst, chk_en = 0;
    logic [CW*N-1:0] m_fhx, m_fhy;
    logic [N-1:0]    m_fh;
    logic [CW-1:0]   m_whx, m_why, m_ix, m_iy, m_fx, m_fy;

    function automatic logic [N-1:0] mask_for(input int lvl);
        int n;
        n = (3 + lvl < N) ? 3 + lvl : N;
        return (n >= N) ? {N{1'b1}} : N'((1 << n) - 1);
    endfunction

    task automatic model_step();
        bit was_first;
        if (!i_rst_n) begin
            m_st = 0; m_rr = 1; m_brst = 0; m_lvl = 0; m_lives = 3; m_score = 0;
            m_fhx = '0; m_fhy = '0; m_fh = '0; m_whx = '0; m_why = '0;
            m_ix = 10'd144; m_iy = 10'd74; m_fx = '0; m_fy = '0;
            chk_en = 1;
        end else if (i_restart) begin
            m_st = 0; m_rr = 1; m_brst = 0; m_lvl = 0; m_lives = 3; m_score = 0;
        end else begin
            was_first = m_rr;
            m_rr = 0; m_brst = 0;
            if (m_st == 0) begin
                if (!was_first && i_rand_ready) begin
                    m_fhx = i_rand_list[0 +: CW*N];
                    m_whx = i_rand_list[CW*N +: CW];
                    m_ix  = i_rand_list[CW*(N+1) +: CW];
                    m_fhy = i_rand_list[HALF +: CW*N];
                    m_why = i_rand_list[HALF+CW*N +: CW];
                    m_iy  = i_rand_list[HALF+CW*(N+1) +: CW];
                    m_fh  = mask_for(m_lvl);
                    m_st = 1; m_brst = 1;
                end
            end else if (m_st == 1) begin
                if (i_fail || i_win) begin
                    m_fx = i_fix_x; m_fy = i_fix_y; m_left = RH;
                    if (i_fail) begin m_st = 2; m_lives--; end
                    else begin m_st = 3; if (m_score < 255) m_score++; end
                end
            end else if (m_st == 2 || m_st == 3) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_st == 2) begin
                        if (m_lives == 0) m_st = 4;
                        else begin m_st = 1; m_brst = 1; end
                    end else begin
                        if (m_lvl == 3) m_st = 5;
                        else begin m_lvl++; m_st = 0; m_rr = 1; end
                    end
                end
            end
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        model_step();
    end

    initial forever begin
        @(negedge i_clk);
        if (chk_en) begin
            check("m_state", o_state, m_st);
            check("m_rand_req", o_rand_req, m_rr);
            check("m_ball_rst", o_ball_rst, m_brst);
            check("m_playing", o_playing, (m_st == 1));
            check("m_level", o_level, m_lvl);
            check("m_lives", o_lives, m_lives);
            check("m_score", o_score, m_score);
            check("m_fh_pos_x", o_fh_pos_x, m_fhx);
            check("m_fh_pos_y", o_fh_pos_y, m_fhy);
            check("m_fh_active", o_fh_active, m_fh);
            check("m_wh_x", o_wh_pos_x, m_whx);
            check("m_wh_y", o_wh_pos_y, m_why);
            check("m_bl_init_x", o_bl_init_x, m_ix);
            check("m_bl_init_y", o_bl_init_y, m_iy);
            check("m_bl_x", o_bl_x, (m_st == 1) ? i_roll_x : (m_st == 0) ? m_ix : m_fx);
            check("m_bl_y", o_bl_y, (m_st == 1) ? i_roll_y : (m_st == 0) ? m_iy : m_fy);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    logic [N-1:0] fh_tab [4];

    initial begin
        fh_tab[0] = 7'h07; fh_tab[1] = 7'h0f; fh_tab[2] = 7'h1f; fh_tab[3] = 7'h3f;
        i_rst_n = 0; i_restart = 0; i_rand_ready = 1; i_fail = 0; i_win = 0;
        i_roll_x = '0; i_roll_y = '0; i_fix_x = '0; i_fix_y = '0;
        i_rand_list = '0;
        for (int k = 0; k < N; k++) begin
            i_rand_list[k*CW +: CW]      = CW'(100 + k*10);
            i_rand_list[HALF+k*CW +: CW] = CW'(200 + k);
        end
        i_rand_list[CW*N +: CW]           = 10'd300;
        i_rand_list[CW*(N+1) +: CW]       = 10'd50;
        i_rand_list[HALF+CW*N +: CW]      = 10'd400;
        i_rand_list[HALF+CW*(N+1) +: CW]  = 10'd60;

        repeat (3) tick();
        check("rst_state", o_state, 0);
        check("rst_rand_req", o_rand_req, 1);
        check("rst_ball_rst", o_ball_rst, 0);
        check("rst_fh_active", o_fh_active, 0);
        check("rst_lives", o_lives, 3);
        check("rst_bl_x", o_bl_x, 144);
        check("rst_bl_init_y", o_bl_init_y, 74);

        // Layout load after reset release
        i_rst_n = 1;
        tick();
        check("load_req_drop", o_rand_req, 0);
        check("load_state", o_state, 0);
        tick();
        check("play_state", o_state, 1);
        check("play_ball_rst", o_ball_rst, 1);
        check("play_fh_active", o_fh_active, 7'b0000111);
        check("play_fh_x0", o_fh_pos_x[0 +: CW], 100);
        check("play_fh_x6", o_fh_pos_x[60 +: CW], 160);
        check("play_fh_y6", o_fh_pos_y[60 +: CW], 206);
        check("play_wh_x", o_wh_pos_x, 300);
        check("play_wh_y", o_wh_pos_y, 400);
        check("play_init_x", o_bl_init_x, 50);
        check("play_init_y", o_bl_init_y, 60);
        tick();
        check("play_ball_rst_drop", o_ball_rst, 0);
        i_roll_x = 10'd11; i_roll_y = 10'd22;
        #1;
        check("roll_x", o_bl_x, 11);
        check("roll_y", o_bl_y, 22);

        // Fail and win together: fail wins
        i_fail = 1; i_win = 1; i_fix_x = 10'd77; i_fix_y = 10'd88;
        tick();
        check("both_state", o_state, 2);
        check("both_lives", o_lives, 2);
        check("both_score", o_score, 0);
        check("both_bl_x", o_bl_x, 77);
        i_fail = 0; i_win = 0;
        repeat (3) begin
            tick();
            check("fail_hold", o_state, 2);
        end
        tick();
        check("fail_back_state", o_state, 1);
        check("fail_back_brst", o_ball_rst, 1);

        // Second and third fails
        i_fail = 1; i_fix_x = 10'd5; i_fix_y = 10'd6;
        tick();
        i_fail = 0;
        repeat (4) tick();
        check("fail2_state", o_state, 1);
        check("fail2_lives", o_lives, 1);
        i_fail = 1; i_fix_x = 10'd33; i_fix_y = 10'd44;
        tick();
        check("fail3_lives", o_lives, 0);
        i_fail = 0;
        repeat (4) tick();
        check("gameover_state", o_state, 4);
        check("gameover_bl_x", o_bl_x, 33);
        check("gameover_bl_y", o_bl_y, 44);
        i_win = 1;
        repeat (2) tick();
        check("gameover_stay", o_state, 4);
        check("gameover_score", o_score, 0);
        i_win = 0;

        // Restart and play through all levels
        i_restart = 1;
        tick();
        check("restart_state", o_state, 0);
        check("restart_req", o_rand_req, 1);
        check("restart_lives", o_lives, 3);
        i_restart = 0;
        tick(); tick();
        check("restart_play", o_state, 1);
        for (int i = 0; i < 4; i++) begin
            i_win = 1; i_fix_x = CW'(i + 1);
            tick();
            check("win_state", o_state, 3);
            check("win_score", o_score, i + 1);
            i_win = 0;
            repeat (4) tick();
            if (i < 3) begin
                check("win_load", o_state, 0);
                check("win_req", o_rand_req, 1);
                check("win_level", o_level, i + 1);
                tick(); tick();
                check("win_play", o_state, 1);
                check("win_fh_active", o_fh_active, fh_tab[i + 1]);
            end else begin
                check("done_state", o_state, 5);
                check("done_score", o_score, 4);
                check("done_level", o_level, 3);
            end
        end

        // Restart during WIN hold cycle 2
        i_restart = 1;
        tick();
        i_restart = 0;
        tick(); tick();
        check("r2_play", o_state, 1);
        i_win = 1;
        tick();
        i_win = 0;
        tick();
        i_restart = 1;
        tick();
        check("midhold_state", o_state, 0);
        check("midhold_score", o_score, 0);
        check("midhold_level", o_level, 0);
        check("midhold_lives", o_lives, 3);
        i_restart = 0;

        // Reset overrides restart
        tick(); tick();
        i_restart = 1; i_rst_n = 0;
        tick();
        check("rr_state", o_state, 0);
        check("rr_req", o_rand_req, 1);
        check("rr_wh_x", o_wh_pos_x, 0);
        check("rr_fh_active", o_fh_active, 0);
        check("rr_init_x", o_bl_init_x, 144);
        check("rr_bl_x", o_bl_x, 144);
        i_restart = 0; i_rand_ready = 0; i_rst_n = 1;
        repeat (3) tick();
        check("wait_state", o_state, 0);
        check("wait_req", o_rand_req, 0);
        i_rand_ready = 1;
        tick();
        check("late_ready_play", o_state, 1);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
